// File: rtl/sb_router_pkg.sv
// sb_router_pkg: shared FSM state encoding and default slave address windows.
`default_nettype none

package sb_router_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_ERR  = 2'd2
    } sb_state_e;

    localparam logic [31:0] ROM_BASE = 32'h0000_0000;
    localparam logic [31:0] ROM_MASK = 32'hFFFF_0000;
    localparam logic [31:0] RAM_BASE = 32'h1000_0000;
    localparam logic [31:0] RAM_MASK = 32'hFFFF_0000;

endpackage

`default_nettype wire

// File: rtl/sb_router_addr_decoder.sv
// sb_addr_decoder: base/mask window compare with lowest-index priority on overlap.
`default_nettype none

module sb_addr_decoder #(
    parameter int                        ADDR_W   = 32,
    parameter int                        NUM_SLV  = 2,
    parameter int                        SEL_W    = 1,
    parameter logic [NUM_SLV*ADDR_W-1:0] SLV_BASE = '0,
    parameter logic [NUM_SLV*ADDR_W-1:0] SLV_MASK = '0
) (
    input  logic [ADDR_W-1:0] addr,
    output logic              hit,
    output logic [SEL_W-1:0]  idx
);

    // Scan from the top so the lowest matching window is the last one written.
    always_comb begin
        hit = 1'b0;
        idx = '0;
        for (int i = NUM_SLV - 1; i >= 0; i--) begin
            if ((addr & SLV_MASK[i*ADDR_W +: ADDR_W]) == SLV_BASE[i*ADDR_W +: ADDR_W]) begin
                hit = 1'b1;
                idx = SEL_W'(i);
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/sb_router.sv
// sb_router: single-master to NUM_SLV-slave bus router with read tracking and error pulse.
// Optional read timeout enabled by defining SB_TIMEOUT_EN.
`default_nettype none

module sb_router
    import sb_router_pkg::*;
#(
    parameter int                        ADDR_W         = 32,
    parameter int                        DATA_W         = 32,
    parameter int                        NUM_SLV        = 2,
    parameter logic [NUM_SLV*ADDR_W-1:0] SLV_BASE       = {RAM_BASE, ROM_BASE},
    parameter logic [NUM_SLV*ADDR_W-1:0] SLV_MASK       = {RAM_MASK, ROM_MASK},
    parameter int                        TIMEOUT_CYCLES = 16
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [ADDR_W-1:0]         sb_m_addr_in,
    input  logic                      sb_m_req_in,
    input  logic                      sb_m_wr_in,
    input  logic [DATA_W-1:0]         sb_m_wdata_in,
    output logic                      sb_m_gnt_out,
    output logic [DATA_W-1:0]         sb_m_read_data_out,
    output logic                      sb_m_read_valid_out,
    output logic                      sb_m_err_out,
    output logic [ADDR_W-1:0]         sb_s_addr_out,
    output logic                      sb_s_wr_out,
    output logic [DATA_W-1:0]         sb_s_wdata_out,
    output logic [NUM_SLV-1:0]        sb_s_req_out,
    input  logic [NUM_SLV*DATA_W-1:0] sb_s_read_data_in,
    input  logic [NUM_SLV-1:0]        sb_s_read_valid_in
);

    localparam int SEL_W = (NUM_SLV > 1) ? $clog2(NUM_SLV) : 1;

    sb_state_e          state, state_nxt;
    logic [SEL_W-1:0]   sel, sel_nxt;
    logic               hit;
    logic [SEL_W-1:0]   hit_idx;
    logic               expired;
    logic               gnt, rvalid, err;
    logic [DATA_W-1:0]  rdata;
    logic [NUM_SLV-1:0] s_req;

    sb_addr_decoder #(
        .ADDR_W   (ADDR_W),
        .NUM_SLV  (NUM_SLV),
        .SEL_W    (SEL_W),
        .SLV_BASE (SLV_BASE),
        .SLV_MASK (SLV_MASK)
    ) u_dec (
        .addr (sb_m_addr_in),
        .hit  (hit),
        .idx  (hit_idx)
    );

`ifdef SB_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [CNT_W-1:0] cnt;

    // Counter runs only while waiting; cleared on every new read grant.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (state == ST_IDLE) begin
            cnt <= '0;
        end else if (state == ST_WAIT && !rvalid && !expired) begin
            cnt <= cnt + 1'b1;
        end
    end

    assign expired = (state == ST_WAIT) && (cnt == CNT_W'(TIMEOUT_CYCLES - 1));
`else
    logic [31:0] unused_timeout_cycles;

    assign unused_timeout_cycles = 32'(TIMEOUT_CYCLES);
    assign expired               = 1'b0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_IDLE;
            sel   <= '0;
        end else begin
            state <= state_nxt;
            sel   <= sel_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        sel_nxt   = sel;
        gnt       = 1'b0;
        s_req     = '0;
        rvalid    = 1'b0;
        rdata     = '0;
        err       = 1'b0;
        case (state)
            ST_IDLE: begin
                if (sb_m_req_in) begin
                    gnt = 1'b1;
                    if (hit) begin
                        for (int i = 0; i < NUM_SLV; i++) begin
                            s_req[i] = (hit_idx == SEL_W'(i));
                        end
                        if (!sb_m_wr_in) begin
                            sel_nxt   = hit_idx;
                            state_nxt = ST_WAIT;
                        end
                    end else begin
                        state_nxt = ST_ERR;
                    end
                end
            end
            ST_WAIT: begin
                rvalid = sb_s_read_valid_in[sel];
                rdata  = sb_s_read_data_in[sel*DATA_W +: DATA_W];
                if (rvalid) begin
                    state_nxt = ST_IDLE;
                end else if (expired) begin
                    state_nxt = ST_ERR;
                end
            end
            ST_ERR: begin
                err       = 1'b1;
                state_nxt = ST_IDLE;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    // Reset forces every output low, including the broadcast path.
    assign sb_m_gnt_out        = gnt & ~rst;
    assign sb_m_read_valid_out = rvalid & ~rst;
    assign sb_m_read_data_out  = rst ? '0 : rdata;
    assign sb_m_err_out        = err & ~rst;
    assign sb_s_req_out        = rst ? '0 : s_req;
    assign sb_s_addr_out       = rst ? '0 : sb_m_addr_in;
    assign sb_s_wr_out         = sb_m_wr_in & ~rst;
    assign sb_s_wdata_out      = rst ? '0 : sb_m_wdata_in;

endmodule

`default_nettype wire

// File: tb/tb_sb_router.sv
// tb_sb_router: directed and randomized checks of sb_router against a transaction-level model.
`default_nettype none

module tb_sb_router;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] m_addr = '0;
    logic        m_req = 1'b0;
    logic        m_wr = 1'b0;
    logic [31:0] m_wdata = '0;
    logic        gnt;
    logic [31:0] rdata;
    logic        rvalid;
    logic        err;
    logic [31:0] s_addr;
    logic        s_wr;
    logic [31:0] s_wdata;
    logic [1:0]  s_req;
    logic [63:0] s_rdata = '0;
    logic [1:0]  s_valid = '0;

    int checks = 0;
    int failures = 0;

    logic [31:0] win_base [2] = '{32'h0000_0000, 32'h1000_0000};
    logic [31:0] win_mask [2] = '{32'hFFFF_0000, 32'hFFFF_0000};

    sb_router dut (
        .clk                 (clk),
        .rst                 (rst),
        .sb_m_addr_in        (m_addr),
        .sb_m_req_in         (m_req),
        .sb_m_wr_in          (m_wr),
        .sb_m_wdata_in       (m_wdata),
        .sb_m_gnt_out        (gnt),
        .sb_m_read_data_out  (rdata),
        .sb_m_read_valid_out (rvalid),
        .sb_m_err_out        (err),
        .sb_s_addr_out       (s_addr),
        .sb_s_wr_out         (s_wr),
        .sb_s_wdata_out      (s_wdata),
        .sb_s_req_out        (s_req),
        .sb_s_read_data_in   (s_rdata),
        .sb_s_read_valid_in  (s_valid)
    );

    always #5 clk = ~clk;

    // Lowest-index window that contains the address, or -1 when unmapped.
    function automatic int decode(input logic [31:0] a);
        for (int i = 0; i < 2; i++) begin
            if ((a & win_mask[i]) == win_base[i]) return i;
        end
        return -1;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic master(input logic req, input logic wr, input logic [31:0] a, input logic [31:0] d);
        m_req = req; m_wr = wr; m_addr = a; m_wdata = d;
    endtask

    task automatic test_reset();
        master(1'b1, 1'b1, 32'h0000_0010, 32'hA5A5_5A5A);
        s_valid = 2'b11;
        s_rdata = {32'h1111_1111, 32'h2222_2222};
        #2;
        checks++; if (gnt !== 1'b0) begin failures++; $display("FAIL rst_gnt got=%0h exp=0", gnt); end
        checks++; if (s_req !== 2'b00) begin failures++; $display("FAIL rst_s_req got=%0h exp=0", s_req); end
        checks++; if (rvalid !== 1'b0 || err !== 1'b0) begin failures++; $display("FAIL rst_valid_err got=%0h/%0h exp=0/0", rvalid, err); end
        checks++; if (rdata !== 32'h0) begin failures++; $display("FAIL rst_rdata got=%0h exp=0", rdata); end
        checks++; if (s_addr !== 32'h0 || s_wr !== 1'b0 || s_wdata !== 32'h0) begin
            failures++; $display("FAIL rst_bcast got=%0h/%0h/%0h exp=0/0/0", s_addr, s_wr, s_wdata); end
        step();
        rst = 1'b0;
        master(1'b0, 1'b0, 32'h0, 32'h0);
        s_valid = 2'b00;
        @(negedge clk);
        checks++; if (gnt !== 1'b0 || rvalid !== 1'b0) begin failures++; $display("FAIL post_rst_idle got=%0h/%0h exp=0/0", gnt, rvalid); end
    endtask

    task automatic test_read_basic();
        step();
        master(1'b1, 1'b0, 32'h0000_0010, 32'h0);
        @(negedge clk);
        checks++; if (gnt !== 1'b1) begin failures++; $display("FAIL rd_gnt got=%0h exp=1", gnt); end
        checks++; if (s_req !== 2'b01) begin failures++; $display("FAIL rd_s_req got=%0h exp=1", s_req); end
        checks++; if (rvalid !== 1'b0) begin failures++; $display("FAIL rd_early_valid got=%0h exp=0", rvalid); end
        step();
        master(1'b0, 1'b0, 32'h0, 32'h0);
        s_rdata = {32'h0BAD_0BAD, 32'hDEAD_BEEF};
        s_valid = 2'b01;
        @(negedge clk);
        checks++; if (rvalid !== 1'b1) begin failures++; $display("FAIL rd_valid got=%0h exp=1", rvalid); end
        checks++; if (rdata !== 32'hDEAD_BEEF) begin failures++; $display("FAIL rd_data got=%0h exp=deadbeef", rdata); end
        checks++; if (gnt !== 1'b0 || s_req !== 2'b00) begin failures++; $display("FAIL rd_wait_quiet got=%0h/%0h exp=0/0", gnt, s_req); end
        step();
        @(negedge clk);
        checks++; if (rvalid !== 1'b0) begin failures++; $display("FAIL rd_idle_valid got=%0h exp=0", rvalid); end
        s_valid = 2'b00;
    endtask

    task automatic test_back_to_back();
        step();
        master(1'b1, 1'b1, 32'h1000_0004, 32'h1234_5678);
        s_valid = 2'b11;
        @(negedge clk);
        checks++; if (gnt !== 1'b1) begin failures++; $display("FAIL wr_gnt got=%0h exp=1", gnt); end
        checks++; if (s_req !== 2'b10) begin failures++; $display("FAIL wr_s_req got=%0h exp=2", s_req); end
        checks++; if (s_wr !== 1'b1 || s_wdata !== 32'h1234_5678 || s_addr !== 32'h1000_0004) begin
            failures++; $display("FAIL wr_bcast got=%0h/%0h/%0h exp=1/12345678/10000004", s_wr, s_wdata, s_addr); end
        checks++; if (rvalid !== 1'b0 || err !== 1'b0) begin failures++; $display("FAIL wr_no_resp got=%0h/%0h exp=0/0", rvalid, err); end
        step();
        master(1'b1, 1'b1, 32'h0000_0008, 32'hCAFE_F00D);
        @(negedge clk);
        checks++; if (gnt !== 1'b1 || s_req !== 2'b01) begin failures++; $display("FAIL wr_b2b got=%0h/%0h exp=1/1", gnt, s_req); end
        checks++; if (rvalid !== 1'b0 || err !== 1'b0) begin failures++; $display("FAIL wr_b2b_resp got=%0h/%0h exp=0/0", rvalid, err); end
        step();
        master(1'b0, 1'b0, 32'h0, 32'h0);
        s_valid = 2'b00;
    endtask

    task automatic test_unmapped();
        step();
        master(1'b1, 1'b0, 32'h2000_0000, 32'h0);
        s_rdata = {32'hFFFF_FFFF, 32'hFFFF_FFFF};
        @(negedge clk);
        checks++; if (gnt !== 1'b1 || s_req !== 2'b00 || err !== 1'b0) begin
            failures++; $display("FAIL um_c0 got=%0h/%0h/%0h exp=1/0/0", gnt, s_req, err); end
        step();
        master(1'b1, 1'b1, 32'h0000_0100, 32'h5);
        s_valid = 2'b11;
        @(negedge clk);
        checks++; if (err !== 1'b1) begin failures++; $display("FAIL um_err got=%0h exp=1", err); end
        checks++; if (gnt !== 1'b0 || rdata !== 32'h0 || rvalid !== 1'b0) begin
            failures++; $display("FAIL um_err_cycle got=%0h/%0h/%0h exp=0/0/0", gnt, rdata, rvalid); end
        step();
        @(negedge clk);
        checks++; if (err !== 1'b0 || gnt !== 1'b1) begin failures++; $display("FAIL um_regrant got=%0h/%0h exp=0/1", err, gnt); end
        step();
        master(1'b0, 1'b0, 32'h0, 32'h0);
        s_valid = 2'b00;
    endtask

`ifdef SB_TIMEOUT_EN
    task automatic test_timeout();
        int bad = 0;
        step();
        master(1'b1, 1'b0, 32'h1000_0040, 32'h0);
        @(negedge clk);
        for (int c = 1; c <= 20; c++) begin
            step();
            master(1'b0, 1'b0, 32'h0, 32'h0);
            s_valid = (c == 5) ? 2'b01 : (c == 20) ? 2'b10 : 2'b00;
            @(negedge clk);
            checks++;
            if (err !== (c == 17) || rvalid !== 1'b0) begin
                failures++; bad++;
                $display("FAIL to_cycle%0d got=%0h/%0h exp=%0h/0", c, err, rvalid, (c == 17));
            end
        end
        s_valid = 2'b00;
        if (bad != 0) $display("timeout sequence had %0d bad cycles", bad);
    endtask

    task automatic test_expiry_race();
        step();
        master(1'b1, 1'b0, 32'h0000_0080, 32'h0);
        @(negedge clk);
        for (int c = 1; c <= 17; c++) begin
            step();
            master(1'b0, 1'b0, 32'h0, 32'h0);
            s_valid = (c == 16) ? 2'b01 : 2'b00;
            s_rdata = {32'h0, 32'h7777_0016};
            @(negedge clk);
            checks++;
            if (rvalid !== (c == 16) || err !== 1'b0) begin
                failures++; $display("FAIL race_cycle%0d got=%0h/%0h exp=%0h/0", c, rvalid, err, (c == 16));
            end
        end
        s_valid = 2'b00;
    endtask
`else
    task automatic test_long_wait();
        step();
        master(1'b1, 1'b0, 32'h1000_0040, 32'h0);
        @(negedge clk);
        for (int c = 1; c <= 22; c++) begin
            step();
            master(1'b0, 1'b0, 32'h0, 32'h0);
            s_valid = (c == 22) ? 2'b10 : 2'b00;
            s_rdata = {32'h5151_2222, 32'h0};
            @(negedge clk);
            checks++;
            if (rvalid !== (c == 22) || err !== 1'b0) begin
                failures++; $display("FAIL long_cycle%0d got=%0h/%0h exp=%0h/0", c, rvalid, err, (c == 22));
            end
        end
        s_valid = 2'b00;
    endtask
`endif

    task automatic test_reset_mid_wait();
        step();
        master(1'b1, 1'b0, 32'h0000_0004, 32'h0);
        step();
        master(1'b0, 1'b0, 32'h0, 32'h0);
        step();
        rst = 1'b1;
        master(1'b1, 1'b0, 32'h0000_0008, 32'h9);
        s_valid = 2'b01;
        s_rdata = {32'h0, 32'h4444_4444};
        #1;
        checks++; if (rvalid !== 1'b0 || gnt !== 1'b0 || s_req !== 2'b00 || s_addr !== 32'h0) begin
            failures++; $display("FAIL rstw_outputs got=%0h/%0h/%0h/%0h exp=0/0/0/0", rvalid, gnt, s_req, s_addr); end
        step();
        rst = 1'b0;
        master(1'b0, 1'b0, 32'h0, 32'h0);
        @(negedge clk);
        checks++; if (rvalid !== 1'b0) begin failures++; $display("FAIL rstw_late_valid got=%0h exp=0", rvalid); end
        step();
        s_valid = 2'b00;
        master(1'b1, 1'b0, 32'h0000_0020, 32'h0);
        @(negedge clk);
        checks++; if (gnt !== 1'b1 || s_req !== 2'b01) begin failures++; $display("FAIL rstw_regrant got=%0h/%0h exp=1/1", gnt, s_req); end
        step();
        master(1'b0, 1'b0, 32'h0, 32'h0);
        s_valid = 2'b01;
        s_rdata = {32'h0, 32'hFEED_0001};
        @(negedge clk);
        checks++; if (rvalid !== 1'b1 || rdata !== 32'hFEED_0001) begin
            failures++; $display("FAIL rstw_fresh_read got=%0h/%0h exp=1/feed0001", rvalid, rdata); end
        step();
        s_valid = 2'b00;
    endtask

    task automatic test_random();
        for (int n = 0; n < 60; n++) begin
            int          r   = $urandom_range(0, 2);
            logic [31:0] a;
            logic        wr  = 1'($urandom_range(0, 1));
            logic [31:0] wd  = $urandom;
            int          lat = $urandom_range(1, 4);
            logic [31:0] rd  = $urandom;
            int          idx;
            logic [1:0]  exp_req;
            if (r == 0)      a = {16'h0000, 16'($urandom)};
            else if (r == 1) a = {16'h1000, 16'($urandom)};
            else             a = {16'($urandom_range(16'h2000, 16'hFFFF)), 16'($urandom)};
            idx     = decode(a);
            exp_req = (idx < 0) ? 2'b00 : (2'b01 << idx);

            step();
            master(1'b1, wr, a, wd);
            s_valid = 2'($urandom);
            @(negedge clk);
            checks++;
            if (gnt !== 1'b1 || s_req !== exp_req || s_addr !== a || s_wr !== wr || rvalid !== 1'b0) begin
                failures++;
                $display("FAIL rnd%0d_issue got=%0h/%0h/%0h/%0h exp=1/%0h/%0h/%0h", n, gnt, s_req, s_addr, rvalid, exp_req, a, wr);
            end

            if (idx < 0) begin
                step();
                master(1'b0, 1'b0, 32'h0, 32'h0);
                @(negedge clk);
                checks++;
                if (err !== 1'b1 || rdata !== 32'h0 || rvalid !== 1'b0) begin
                    failures++; $display("FAIL rnd%0d_unmapped got=%0h/%0h/%0h exp=1/0/0", n, err, rdata, rvalid);
                end
            end else if (!wr) begin
                for (int k = 1; k <= lat; k++) begin
                    step();
                    master(1'b0, 1'b0, 32'h0, 32'h0);
                    s_rdata = {32'($urandom), 32'($urandom)};
                    s_valid = 2'($urandom);
                    s_valid[idx] = (k == lat);
                    if (k == lat) s_rdata[idx*32 +: 32] = rd;
                    @(negedge clk);
                    checks++;
                    if (rvalid !== (k == lat) || err !== 1'b0 || ((k == lat) && rdata !== rd)) begin
                        failures++;
                        $display("FAIL rnd%0d_rd_k%0d got=%0h/%0h/%0h exp=%0h/0/%0h", n, k, rvalid, err, rdata, (k == lat), rd);
                    end
                end
            end

            step();
            master(1'b0, 1'b0, 32'h0, 32'h0);
            s_valid = 2'($urandom);
            @(negedge clk);
            checks++;
            if (rvalid !== 1'b0 || err !== 1'b0 || gnt !== 1'b0) begin
                failures++; $display("FAIL rnd%0d_gap got=%0h/%0h/%0h exp=0/0/0", n, rvalid, err, gnt);
            end
            s_valid = 2'b00;
        end
    endtask

    initial begin
        test_reset();
        test_read_basic();
        test_back_to_back();
        test_unmapped();
`ifdef SB_TIMEOUT_EN
        test_timeout();
        test_expiry_race();
`else
        test_long_wait();
`endif
        test_reset_mid_wait();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

endmodule

`default_nettype wire
